// File: rtl/adder_pkg.sv
// adder_pkg: shared widths and entry types for the adder result collector.
// Define ADDER_COLLECT_TIMESTAMP_EN to add a timestamp field to each entry.
package adder_pkg;
  localparam int ADDER_DATA_W = 10;
  localparam int ADDER_TS_W = 16;
  typedef logic [ADDER_DATA_W:0] adder_result_t;
  typedef struct packed {
    adder_result_t result;
`ifdef ADDER_COLLECT_TIMESTAMP_EN
    logic [ADDER_TS_W-1:0] ts;
`endif
  } collect_entry_t;
endpackage

// File: rtl/adder_collect_fifo.sv
// adder_collect_fifo: first-word-fall-through FIFO with explicit occupancy count.
// Ports: SystemClock/nReset (async, active-low), clear (sync flush),
//   push/wdata (caller guarantees room), pop (caller guarantees level != 0),
//   rdata (head; last popped entry, reset 0, when empty), level (0..DEPTH).
module adder_collect_fifo #(
  parameter int DEPTH = 4,
  parameter type T = logic [10:0],
  localparam int AW = $clog2(DEPTH)
) (
  input  logic SystemClock,
  input  logic nReset,
  input  logic clear,
  input  logic push,
  input  logic pop,
  input  T wdata,
  output T rdata,
  output logic [AW:0] level
);
  T mem [DEPTH];
  T last;
  logic [AW-1:0] wp, rp;
  always_ff @(posedge SystemClock or negedge nReset)
    if (!nReset) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
      last <= '0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) begin
        rp <= rp + AW'(1);
        last <= mem[rp];
      end
      level <= (push && !pop) ? level + (AW+1)'(1) : (!push && pop) ? level - (AW+1)'(1) : level;
    end
  always_ff @(posedge SystemClock)
    if (push && !clear) mem[wp] <= wdata;
  // Keeping the last popped entry makes the empty head stable rather than stale storage.
  assign rdata = (level != '0) ? mem[rp] : last;
endmodule

// File: rtl/adder_result_collector.sv
// adder_result_collector: captures adder results into a FWFT FIFO with accept/drop statistics.
// Ports: SystemClock, nReset (async, active-low), i_valid/i_result (adder output),
//   i_clear (sync flush of FIFO, flags, counters), o_rd_valid/i_rd_ready/o_rd_data (read port),
//   o_level, o_overflow (sticky), o_acc_cnt (wraps), o_drop_cnt (saturates).
// Define ADDER_COLLECT_TIMESTAMP_EN to add a free-running timestamp and the o_rd_ts port.
module adder_result_collector
  import adder_pkg::*;
#(
  parameter int DATA_W = ADDER_DATA_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  parameter int TS_W = ADDER_TS_W
) (
  input  logic SystemClock,
  input  logic nReset,
  input  logic i_valid,
  input  logic [DATA_W:0] i_result,
  input  logic i_clear,
  output logic o_rd_valid,
  input  logic i_rd_ready,
  output logic [DATA_W:0] o_rd_data,
`ifdef ADDER_COLLECT_TIMESTAMP_EN
  output logic [TS_W-1:0] o_rd_ts,
`endif
  output logic [$clog2(DEPTH):0] o_level,
  output logic o_overflow,
  output logic [CNT_W-1:0] o_acc_cnt,
  output logic [CNT_W-1:0] o_drop_cnt
);
  localparam int LW = $clog2(DEPTH) + 1;
  collect_entry_t wr_entry, rd_entry;
  logic pop, push, drop;
  assign o_rd_valid = o_level != '0;
  assign pop = o_rd_valid & i_rd_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push = i_valid & ((o_level < LW'(DEPTH)) | pop);
  assign drop = i_valid & ~push;
`ifdef ADDER_COLLECT_TIMESTAMP_EN
  logic [TS_W-1:0] ts;
  always_ff @(posedge SystemClock or negedge nReset)
    if (!nReset) ts <= '0;
    else ts <= i_clear ? '0 : ts + TS_W'(1);
  assign o_rd_ts = rd_entry.ts;
`endif
  always_comb begin
    wr_entry = '0;
    wr_entry.result = i_result;
`ifdef ADDER_COLLECT_TIMESTAMP_EN
    wr_entry.ts = ts;
`endif
  end
  assign o_rd_data = rd_entry.result;
  adder_collect_fifo #(.DEPTH(DEPTH), .T(collect_entry_t)) u_fifo (
    .SystemClock(SystemClock),
    .nReset(nReset),
    .clear(i_clear),
    .push(push),
    .pop(pop),
    .wdata(wr_entry),
    .rdata(rd_entry),
    .level(o_level)
  );
  always_ff @(posedge SystemClock or negedge nReset)
    if (!nReset) begin
      o_overflow <= 1'b0;
      o_acc_cnt <= '0;
      o_drop_cnt <= '0;
    end else if (i_clear) begin
      o_overflow <= 1'b0;
      o_acc_cnt <= '0;
      o_drop_cnt <= '0;
    end else begin
      if (push) o_acc_cnt <= o_acc_cnt + CNT_W'(1);
      if (drop) begin
        o_overflow <= 1'b1;
        if (~&o_drop_cnt) o_drop_cnt <= o_drop_cnt + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_adder_result_collector.sv
// tb_adder_result_collector: directed self-checking bench for adder_result_collector.
module tb_adder_result_collector;
  logic SystemClock = 1'b0;
  logic nReset = 1'b0;
  logic i_valid = 1'b0;
  logic [10:0] i_result = '0;
  logic i_clear = 1'b0;
  logic i_rd_ready = 1'b0;
  logic o_rd_valid, o_overflow;
  logic [10:0] o_rd_data;
  logic [2:0] o_level;
  logic [15:0] o_acc_cnt, o_drop_cnt;
`ifdef ADDER_COLLECT_TIMESTAMP_EN
  logic [15:0] o_rd_ts;
`endif
  int tests = 0;
  int fails = 0;

  always #5 SystemClock = ~SystemClock;

  adder_result_collector dut (
    .SystemClock(SystemClock),
    .nReset(nReset),
    .i_valid(i_valid),
    .i_result(i_result),
    .i_clear(i_clear),
    .o_rd_valid(o_rd_valid),
    .i_rd_ready(i_rd_ready),
    .o_rd_data(o_rd_data),
`ifdef ADDER_COLLECT_TIMESTAMP_EN
    .o_rd_ts(o_rd_ts),
`endif
    .o_level(o_level),
    .o_overflow(o_overflow),
    .o_acc_cnt(o_acc_cnt),
    .o_drop_cnt(o_drop_cnt)
  );

  task automatic cyc;
    @(posedge SystemClock);
    #1;
  endtask

  task automatic do_clear;
    i_clear = 1'b1;
    cyc();
    i_clear = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    tests++; if (o_level !== 3'd0 || o_rd_valid !== 1'b0) begin fails++; $display("FAIL reset_level got level=%0d valid=%b want 0/0", o_level, o_rd_valid); end
    tests++; if (o_rd_data !== 11'd0) begin fails++; $display("FAIL reset_data got %0d want 0", o_rd_data); end
    tests++; if (o_acc_cnt !== 16'd0 || o_drop_cnt !== 16'd0 || o_overflow !== 1'b0) begin fails++; $display("FAIL reset_stats got acc=%0d drop=%0d ovf=%b want 0/0/0", o_acc_cnt, o_drop_cnt, o_overflow); end
    @(negedge SystemClock);
    nReset = 1'b1;
    cyc();
  endtask

  task automatic test_single;
    logic [10:0] vals [2];
    vals[0] = 11'd61;
    vals[1] = 11'd98;
    i_rd_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      i_valid = 1'b1;
      i_result = vals[i];
      #1;
      tests++; if (o_rd_valid !== 1'b0) begin fails++; $display("FAIL single_nobypass%0d got valid=%b want 0", i, o_rd_valid); end
      cyc();
      i_valid = 1'b0;
      tests++; if (o_rd_valid !== 1'b1 || o_rd_data !== vals[i]) begin fails++; $display("FAIL single_head%0d got valid=%b data=%0d want 1/%0d", i, o_rd_valid, o_rd_data, vals[i]); end
      cyc();
      tests++; if (o_rd_valid !== 1'b0 || o_rd_data !== vals[i]) begin fails++; $display("FAIL single_hold%0d got valid=%b data=%0d want 0/%0d", i, o_rd_valid, o_rd_data, vals[i]); end
      cyc();
    end
    i_rd_ready = 1'b0;
    tests++; if (o_acc_cnt !== 16'd2 || o_overflow !== 1'b0) begin fails++; $display("FAIL single_stats got acc=%0d ovf=%b want 2/0", o_acc_cnt, o_overflow); end
  endtask

  task automatic test_overflow;
    do_clear();
    for (int v = 1; v <= 5; v++) begin
      i_valid = 1'b1;
      i_result = 11'(v);
      cyc();
    end
    i_valid = 1'b0;
    tests++; if (o_level !== 3'd4 || o_overflow !== 1'b1) begin fails++; $display("FAIL ovf_level got level=%0d ovf=%b want 4/1", o_level, o_overflow); end
    tests++; if (o_drop_cnt !== 16'd1 || o_acc_cnt !== 16'd4) begin fails++; $display("FAIL ovf_counts got drop=%0d acc=%0d want 1/4", o_drop_cnt, o_acc_cnt); end
    i_rd_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      tests++; if (o_rd_valid !== 1'b1 || o_rd_data !== 11'(v)) begin fails++; $display("FAIL ovf_drain%0d got valid=%b data=%0d want 1/%0d", v, o_rd_valid, o_rd_data, v); end
      cyc();
    end
    i_rd_ready = 1'b0;
    tests++; if (o_level !== 3'd0 || o_overflow !== 1'b1) begin fails++; $display("FAIL ovf_after got level=%0d ovf=%b want 0/1", o_level, o_overflow); end
  endtask

  task automatic test_push_pop;
    logic [10:0] exp [4];
    exp[0] = 11'd2;
    exp[1] = 11'd3;
    exp[2] = 11'd4;
    exp[3] = 11'd9;
    do_clear();
    for (int v = 1; v <= 4; v++) begin
      i_valid = 1'b1;
      i_result = 11'(v);
      cyc();
    end
    i_result = 11'd9;
    i_rd_ready = 1'b1;
    cyc();
    i_valid = 1'b0;
    i_rd_ready = 1'b0;
    tests++; if (o_level !== 3'd4 || o_rd_data !== 11'd2) begin fails++; $display("FAIL pp_full got level=%0d head=%0d want 4/2", o_level, o_rd_data); end
    tests++; if (o_overflow !== 1'b0 || o_acc_cnt !== 16'd5 || o_drop_cnt !== 16'd0) begin fails++; $display("FAIL pp_stats got ovf=%b acc=%0d drop=%0d want 0/5/0", o_overflow, o_acc_cnt, o_drop_cnt); end
    i_rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (o_rd_valid !== 1'b1 || o_rd_data !== exp[i]) begin fails++; $display("FAIL pp_drain%0d got valid=%b data=%0d want 1/%0d", i, o_rd_valid, o_rd_data, exp[i]); end
      cyc();
    end
    i_rd_ready = 1'b0;
    i_valid = 1'b1;
    i_result = 11'd3;
    cyc();
    i_result = 11'd6;
    i_rd_ready = 1'b1;
    cyc();
    i_valid = 1'b0;
    i_rd_ready = 1'b0;
    tests++; if (o_level !== 3'd1 || o_rd_data !== 11'd6) begin fails++; $display("FAIL pp_level1 got level=%0d head=%0d want 1/6", o_level, o_rd_data); end
  endtask

  task automatic test_clear;
    do_clear();
    for (int v = 1; v <= 5; v++) begin
      i_valid = 1'b1;
      i_result = 11'(v + 9);
      cyc();
    end
    i_valid = 1'b0;
    i_rd_ready = 1'b1;
    cyc();
    i_rd_ready = 1'b0;
    tests++; if (o_level !== 3'd3 || o_overflow !== 1'b1) begin fails++; $display("FAIL clr_pre got level=%0d ovf=%b want 3/1", o_level, o_overflow); end
    i_clear = 1'b1;
    i_valid = 1'b1;
    i_result = 11'd7;
    cyc();
    i_clear = 1'b0;
    i_valid = 1'b0;
    tests++; if (o_level !== 3'd0 || o_rd_valid !== 1'b0) begin fails++; $display("FAIL clr_level got level=%0d valid=%b want 0/0", o_level, o_rd_valid); end
    tests++; if (o_acc_cnt !== 16'd0 || o_drop_cnt !== 16'd0 || o_overflow !== 1'b0) begin fails++; $display("FAIL clr_stats got acc=%0d drop=%0d ovf=%b want 0/0/0", o_acc_cnt, o_drop_cnt, o_overflow); end
    i_valid = 1'b1;
    i_result = 11'd8;
    cyc();
    i_valid = 1'b0;
    tests++; if (o_level !== 3'd1 || o_rd_data !== 11'd8 || o_acc_cnt !== 16'd1) begin fails++; $display("FAIL clr_after got level=%0d head=%0d acc=%0d want 1/8/1", o_level, o_rd_data, o_acc_cnt); end
  endtask

  task automatic test_reset_mid;
    do_clear();
    i_valid = 1'b1;
    i_result = 11'd20;
    cyc();
    i_result = 11'd21;
    cyc();
    i_valid = 1'b0;
    tests++; if (o_level !== 3'd2 || o_rd_data !== 11'd20) begin fails++; $display("FAIL rst_pre got level=%0d head=%0d want 2/20", o_level, o_rd_data); end
    #2;
    nReset = 1'b0;
    #1;
    tests++; if (o_level !== 3'd0 || o_rd_valid !== 1'b0 || o_rd_data !== 11'd0) begin fails++; $display("FAIL rst_async got level=%0d valid=%b data=%0d want 0/0/0", o_level, o_rd_valid, o_rd_data); end
    tests++; if (o_acc_cnt !== 16'd0 || o_drop_cnt !== 16'd0 || o_overflow !== 1'b0) begin fails++; $display("FAIL rst_stats got acc=%0d drop=%0d ovf=%b want 0/0/0", o_acc_cnt, o_drop_cnt, o_overflow); end
    @(negedge SystemClock);
    nReset = 1'b1;
    cyc();
    i_valid = 1'b1;
    i_result = 11'd2047;
    cyc();
    i_valid = 1'b0;
    tests++; if (o_level !== 3'd1 || o_rd_data !== 11'd2047 || o_acc_cnt !== 16'd1) begin fails++; $display("FAIL rst_after got level=%0d head=%0d acc=%0d want 1/2047/1", o_level, o_rd_data, o_acc_cnt); end
  endtask

`ifdef ADDER_COLLECT_TIMESTAMP_EN
  task automatic test_timestamp;
    do_clear();
    repeat (5) cyc();
    i_valid = 1'b1;
    i_result = 11'd100;
    cyc();
    i_valid = 1'b0;
    repeat (6) cyc();
    i_valid = 1'b1;
    i_result = 11'd200;
    cyc();
    i_valid = 1'b0;
    tests++; if (o_rd_data !== 11'd100 || o_rd_ts !== 16'd5) begin fails++; $display("FAIL ts_first got data=%0d ts=%0d want 100/5", o_rd_data, o_rd_ts); end
    i_rd_ready = 1'b1;
    cyc();
    i_rd_ready = 1'b0;
    tests++; if (o_rd_data !== 11'd200 || o_rd_ts !== 16'd12) begin fails++; $display("FAIL ts_second got data=%0d ts=%0d want 200/12", o_rd_data, o_rd_ts); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_push_pop();
    test_clear();
    test_reset_mid();
`ifdef ADDER_COLLECT_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
